ahb_sram_master: RTL and testbench
==================================

Name: ahb_sram_master

Overview:
- Single-transfer AHB-style bus master sitting between the local buffer/SRAM side and the bus.
- A one-cycle `we` or `re` request launches one write or read transfer: address, direction and write data are driven and held until the slave signals `hready`.
- Completion is reported with a one-cycle `write_complete` / `read_complete` pulse.
- Read data arriving on `sram_data` is presented on `hrdata`.

Parameters:
- ADDR_W, 32, address width of `next_waddr`, `next_raddr`, `haddr`.
- DATA_W, 32, data width of `buffer2_data`, `sram_data`, `hwdata`, `hrdata`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  reset; synchronous, active-low.
- hready  in  1  slave ready; ends the current transfer.
- re  in  1  read request, sampled in IDLE only.
- we  in  1  write request, sampled in IDLE only.
- next_waddr  in  ADDR_W  address for the next write.
- next_raddr  in  ADDR_W  address for the next read.
- buffer2_data  in  DATA_W  write data source.
- sram_data  in  DATA_W  read data source.
- haddr  out  ADDR_W  registered bus address.
- hrdata  out  DATA_W  registered read data.
- hwdata  out  DATA_W  registered write data.
- read_complete  out  1  one-cycle read-done pulse, registered.
- hwrite  out  1  registered direction: 1 = write, 0 = read.
- write_complete  out  1  one-cycle write-done pulse, registered.

Behaviour:
- Reset: on a rising edge with `n_rst` = 0, the FSM goes to IDLE and all outputs clear: `haddr` = 0, `hwdata` = 0, `hrdata` = 0, `hwrite` = 0, `read_complete` = 0, `write_complete` = 0.
  - Reset mid-transfer aborts the transfer; no completion pulse is produced.
- FSM states: IDLE, WR_WAIT, RD_WAIT.
- IDLE:
  - `hready` is ignored; a spurious `hready` never produces a completion.
  - `re` = 1 → RD_WAIT. Latch `haddr` ← `next_raddr`, `hwrite` ← 0, `hrdata` ← `sram_data`.
  - Else `we` = 1 → WR_WAIT. Latch `haddr` ← `next_waddr`, `hwrite` ← 1, `hwdata` ← `buffer2_data`.
  - `re` and `we` together: read wins; the write request is dropped.
  - Neither asserted: stay in IDLE, outputs hold.
- Request latency: `haddr`, `hwrite` and `hwdata`/`hrdata` are valid one cycle after the edge that samples the request.
- WR_WAIT:
  - Hold `haddr`, `hwrite`, `hwdata`.
  - `hready` = 1 at an edge → IDLE and `write_complete` ← 1 for exactly one cycle.
  - `hready` = 0 → wait state; remain in WR_WAIT indefinitely.
- RD_WAIT:
  - Hold `haddr` and `hwrite`.
  - Each cycle, `hrdata` ← `sram_data`.
  - `hready` = 1 → IDLE and `read_complete` ← 1 for one cycle.
- Zero wait states: `hready` high at the first edge in the WAIT state completes the transfer. Minimum transfer is request edge → completion edge, 2 cycles.
- Requests arriving in a WAIT state are ignored, not queued.
- A new request may be accepted in the IDLE cycle in which the completion pulse is high (back-to-back).
- `read_complete` and `write_complete` are never high together and are 0 in every non-completion cycle.
- `haddr`, `hwrite` and `hwdata` retain their last values in IDLE.

Decomposition:
- Package `ahb_master_pkg`: state enum {IDLE, WR_WAIT, RD_WAIT}, ADDR_W / DATA_W constants.
- Single module; the FSM plus output registers is small enough to need no sub-module.

Test Plan:
- Basic write: `next_waddr` = k, `buffer2_data` = {FFFFFFFF, 00000000, AAAAAAAA, 55555555}[k], pulse `we`.
  - Next cycle: `haddr` = k, `hwrite` = 1, `hwdata` = data.
  - Hold `hready` low 1 cycle, then high 1 cycle → `write_complete` = 1 for 1 cycle.
- Basic read: `next_raddr` = k, `sram_data` = same patterns, pulse `re`.
  - Next cycle: `haddr` = k, `hwrite` = 0, `hrdata` = data.
  - One wait state, then `hready` → `read_complete` = 1 for one cycle.
- Zero-wait read: raise `hready` in the first RD_WAIT cycle → `read_complete` = 1 at the next edge. Repeat with write → `write_complete`.
- Spurious ready: immediately after reset, `hready` = 1 with `re` = 1, or with `we` = 1 → after one edge both completes = 0.
- Simultaneous request: after reset, `re` = `we` = 1 with addresses 0xFFFFFFFF → next cycle `hwrite` = 0 and `haddr` = `next_raddr`.
- Reset mid-transfer: enter WR_WAIT, drive `n_rst` = 0 for one edge, then `hready` = 1 → no `write_complete`; all outputs 0 after the reset edge.

Source files
------------

// File: rtl/ahb_master_pkg.sv
// Shared types and default widths for the single-transfer AHB SRAM master.
package ahb_master_pkg;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/ahb_sram_master.sv
// Single-transfer AHB-style master: one we/re request launches one bus transfer,
// held until hready, with a one-cycle completion pulse.
module ahb_sram_master
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hready,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] next_waddr,
  input  logic [ADDR_W-1:0] next_raddr,
  input  logic [DATA_W-1:0] buffer2_data,
  input  logic [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hrdata,
  output logic [DATA_W-1:0] hwdata,
  output logic              read_complete,
  output logic              hwrite,
  output logic              write_complete
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              hwrite_q, hwrite_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    hrdata_d  = hrdata_q;
    hwdata_d  = hwdata_q;
    hwrite_d  = hwrite_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // hready is deliberately ignored here; read wins over a concurrent write
        if (re) begin
          state_d  = RD_WAIT;
          haddr_d  = next_raddr;
          hwrite_d = 1'b0;
          hrdata_d = sram_data;
        end else if (we) begin
          state_d  = WR_WAIT;
          haddr_d  = next_waddr;
          hwrite_d = 1'b1;
          hwdata_d = buffer2_data;
        end
      end
      WR_WAIT: begin
        if (hready) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
      end
      RD_WAIT: begin
        hrdata_d = sram_data;
        if (hready) begin
          state_d   = IDLE;
          rd_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      haddr_q   <= '0;
      hrdata_q  <= '0;
      hwdata_q  <= '0;
      hwrite_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hrdata_q  <= hrdata_d;
      hwdata_q  <= hwdata_d;
      hwrite_q  <= hwrite_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign haddr          = haddr_q;
  assign hrdata         = hrdata_q;
  assign hwdata         = hwdata_q;
  assign hwrite         = hwrite_q;
  assign read_complete  = rd_done_q;
  assign write_complete = wr_done_q;

endmodule

// File: tb/tb_ahb_sram_master.sv
// Randomized scoreboard bench: stimulus pushes expected completions, a negedge
// monitor pops and compares whenever a completion pulse appears.
module tb_ahb_sram_master;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        hready = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] next_waddr = '0;
  logic [31:0] next_raddr = '0;
  logic [31:0] buffer2_data = '0;
  logic [31:0] sram_data = '0;
  logic [31:0] haddr, hrdata, hwdata;
  logic        read_complete, hwrite, write_complete;

  ahb_sram_master dut (
    .clk(clk), .n_rst(n_rst), .hready(hready), .re(re), .we(we),
    .next_waddr(next_waddr), .next_raddr(next_raddr),
    .buffer2_data(buffer2_data), .sram_data(sram_data),
    .haddr(haddr), .hrdata(hrdata), .hwdata(hwdata),
    .read_complete(read_complete), .hwrite(hwrite),
    .write_complete(write_complete)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every completion pulse must match the oldest outstanding transfer
  always @(negedge clk) begin
    if (write_complete || read_complete) begin
      chk("pulse_exclusive", {30'd0, write_complete, read_complete} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: wc=%0b rc=%0b, expected no pulse @%0t",
                 write_complete, read_complete, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmpl_kind_wc", {31'd0, write_complete}, {31'd0, e.wr});
        chk("cmpl_kind_rc", {31'd0, read_complete}, {31'd0, !e.wr});
        chk("cmpl_haddr", haddr, e.addr);
        chk("cmpl_hwrite", {31'd0, hwrite}, {31'd0, e.wr});
        if (e.wr) chk("cmpl_hwdata", hwdata, e.data);
        else      chk("cmpl_hrdata", hrdata, e.data);
      end
    end
  end

  task automatic do_reset();
    n_rst = 1'b0; re = 1'b0; we = 1'b0; hready = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_haddr"}, haddr, 32'd0);
    chk({nm, "_hwdata"}, hwdata, 32'd0);
    chk({nm, "_hrdata"}, hrdata, 32'd0);
    chk({nm, "_hwrite"}, {31'd0, hwrite}, 32'd0);
    chk({nm, "_rc"}, {31'd0, read_complete}, 32'd0);
    chk({nm, "_wc"}, {31'd0, write_complete}, 32'd0);
  endtask

  // wait-state cycles: stray requests and changing sources must be ignored
  task automatic wait_cycles(input int waits, input bit rd);
    hready = 1'b0;
    repeat (waits) begin
      re = 1'($urandom); we = 1'($urandom);
      next_waddr = $urandom; next_raddr = $urandom; buffer2_data = $urandom;
      if (rd) sram_data = $urandom;
      tick();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int waits);
    exp_t e;
    next_waddr = a; buffer2_data = d; we = 1'b1; re = 1'b0;
    tick();
    we = 1'b0;
    next_waddr = ~a; buffer2_data = ~d;
    chk("wr_haddr", haddr, a);
    chk("wr_hwrite", {31'd0, hwrite}, 32'd1);
    chk("wr_hwdata", hwdata, d);
    wait_cycles(waits, 1'b0);
    e.wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
    hready = 1'b1; re = 1'($urandom); we = 1'($urandom);
    tick();
    hready = 1'b0; re = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int waits);
    exp_t e;
    logic [31:0] last;
    next_raddr = a; sram_data = d; re = 1'b1; we = 1'($urandom);
    tick();
    re = 1'b0; we = 1'b0;
    next_raddr = ~a;
    chk("rd_haddr", haddr, a);
    chk("rd_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rd_hrdata", hrdata, d);
    wait_cycles(waits, 1'b1);
    // hrdata tracks sram_data every wait cycle, including the completing edge
    last = (waits == 0) ? d : $urandom;
    sram_data = last;
    e.wr = 1'b0; e.addr = a; e.data = last;
    exp_q.push_back(e);
    hready = 1'b1; re = 1'($urandom); we = 1'($urandom);
    tick();
    hready = 1'b0; re = 1'b0; we = 1'b0;
  endtask

  logic [31:0] pat [4];

  initial begin
    exp_t e;
    pat[0] = 32'hFFFF_FFFF; pat[1] = 32'h0000_0000;
    pat[2] = 32'hAAAA_AAAA; pat[3] = 32'h5555_5555;

    do_reset();
    chk_all_zero("reset");

    // spurious ready with a read request: no completion on the request edge
    hready = 1'b1; re = 1'b1; next_raddr = 32'h0000_0040; sram_data = 32'h1234_5678;
    tick();
    re = 1'b0;
    chk("spur_rd_rc", {31'd0, read_complete}, 32'd0);
    chk("spur_rd_wc", {31'd0, write_complete}, 32'd0);
    // hready still high in first RD_WAIT cycle: zero-wait completion
    e.wr = 1'b0; e.addr = 32'h0000_0040; e.data = 32'h1234_5678;
    exp_q.push_back(e);
    tick();
    hready = 1'b0;

    do_reset();
    hready = 1'b1; we = 1'b1; next_waddr = 32'h0000_0080; buffer2_data = 32'hCAFE_F00D;
    tick();
    we = 1'b0;
    chk("spur_wr_rc", {31'd0, read_complete}, 32'd0);
    chk("spur_wr_wc", {31'd0, write_complete}, 32'd0);
    e.wr = 1'b1; e.addr = 32'h0000_0080; e.data = 32'hCAFE_F00D;
    exp_q.push_back(e);
    tick();
    hready = 1'b0;

    // simultaneous re/we: read wins
    do_reset();
    re = 1'b1; we = 1'b1; next_raddr = 32'hFFFF_FFFF; next_waddr = 32'hFFFF_FFFF;
    sram_data = 32'h0BAD_BEEF; buffer2_data = 32'h1111_2222;
    tick();
    re = 1'b0; we = 1'b0;
    chk("simul_hwrite", {31'd0, hwrite}, 32'd0);
    chk("simul_haddr", haddr, 32'hFFFF_FFFF);
    chk("simul_hwdata", hwdata, 32'd0);
    e.wr = 1'b0; e.addr = 32'hFFFF_FFFF; e.data = 32'h0BAD_BEEF;
    exp_q.push_back(e);
    hready = 1'b1;
    tick();
    hready = 1'b0;

    // basic patterns, one wait state each
    for (int k = 0; k < 4; k++) do_write(k, pat[k], 1);
    for (int k = 0; k < 4; k++) do_read(k, pat[k], 1);
    do_read(32'h0000_0100, 32'hDEAD_0001, 0);
    do_write(32'h0000_0104, 32'hDEAD_0002, 0);

    // outputs retain their values while idle
    repeat (3) begin
      next_waddr = $urandom; buffer2_data = $urandom; hready = 1'($urandom);
      tick();
    end
    hready = 1'b0;
    chk("idle_hold_haddr", haddr, 32'h0000_0104);
    chk("idle_hold_hwdata", hwdata, 32'hDEAD_0002);
    chk("idle_hold_hwrite", {31'd0, hwrite}, 32'd1);

    // randomized back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) do_write($urandom, $urandom, $urandom_range(3, 0));
      else                           do_read($urandom, $urandom, $urandom_range(3, 0));
    end

    // reset mid-transfer aborts without completion
    next_waddr = 32'h0000_0200; buffer2_data = 32'h7777_7777; we = 1'b1;
    tick();
    we = 1'b0;
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk_all_zero("midrst");
    hready = 1'b1;
    tick();
    hready = 1'b0;
    chk("midrst_no_wc", {31'd0, write_complete}, 32'd0);
    tick();

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
